jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1-style TAP controller that sequences the boundary-scan register chain.
- Runs the 16-state TAP FSM from TMS and holds the instruction register (IR) and the 1-bit bypass register.
- Generates the shift_dr, capture_dr, update_dr and mode controls that drive every bsr cell, and muxes TDO.
- Sits between the chip JTAG pins and the head and tail of the boundary-scan chain.

---
 rtl/jtag_tap_ctrl.sv | 120 ++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the boundary-scan chain: 16-state TMS FSM, instruction
// register, bypass bit, BSR cell controls and TDO mux.
module jtag_tap_ctrl #(
   parameter int              IR_W      = 4,
   parameter logic [IR_W-1:0] EXTEST_OP = '0,
   parameter logic [IR_W-1:0] SAMPLE_OP = {{(IR_W-1){1'b0}}, 1'b1},
   parameter logic [IR_W-1:0] BYPASS_OP = '1
) (
   input  logic            TCK,
   input  logic            TRST,
   input  logic            TMS,
   input  logic            TDI,
   input  logic            bsr_scan_out,
   output logic            TDO,
   output logic            tdo_en,
   output logic            bsr_scan_in,
   output logic            shift_dr,
   output logic            capture_dr,
   output logic            update_dr,
   output logic            mode,
   output logic [IR_W-1:0] ir_out,
   output logic [3:0]      tap_state
);

   // state  | meaning
   // TLR    | test-logic-reset, IR forced to bypass
   // RTI    | run-test/idle
   // SEL_xx | select DR / IR column
   // CAP_xx | capture into DR / IR shift register
   // SH_xx  | shift TDI -> TDO
   // EX1_xx | exit-1 (to update or pause)
   // PAU_xx | pause, all registers hold
   // EX2_xx | exit-2 (back to shift or update)
   // UPD_xx | update DR / IR
   typedef enum logic [3:0] {
      EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
      SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
      EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
      RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
   } tap_state_e;

   localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};

   tap_state_e      state_q;
   tap_state_e      state_d;
   logic [IR_W-1:0] ir_q;
   logic [IR_W-1:0] ir_sr_q;
   logic            bypass_q;
   logic            bsr_sel;

   always_ff @(posedge TCK) begin
      if (TRST) state_q <= TLR;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = TLR;
      case (state_q)
         TLR:    state_d = TMS ? TLR    : RTI;
         RTI:    state_d = TMS ? SEL_DR : RTI;
         SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
         CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
         SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
         EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
         PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
         EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
         UPD_DR: state_d = TMS ? SEL_DR : RTI;
         SEL_IR: state_d = TMS ? TLR    : CAP_IR;
         CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
         SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
         EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
         PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
         EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
         UPD_IR: state_d = TMS ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   // Undefined opcodes fall through to the bypass path.
   assign bsr_sel = (ir_q == EXTEST_OP) || (ir_q == SAMPLE_OP);

   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir_q       <= BYPASS_OP;
         ir_sr_q    <= '0;
         bypass_q   <= 1'b0;
         shift_dr   <= 1'b0;
         capture_dr <= 1'b0;
         update_dr  <= 1'b0;
         tdo_en     <= 1'b0;
      end else begin
         if (state_q == CAP_IR)     ir_sr_q <= IR_CAPTURE;
         else if (state_q == SH_IR) ir_sr_q <= {TDI, ir_sr_q[IR_W-1:1]};

         if (state_q == CAP_DR)     bypass_q <= 1'b0;
         else if (state_q == SH_DR) bypass_q <= TDI;

         if (state_d == TLR)         ir_q <= BYPASS_OP;
         else if (state_q == UPD_IR) ir_q <= ir_sr_q;

         // Decoded from the next state so each pulse lines up with its state.
         capture_dr <= bsr_sel && (state_d == CAP_DR);
         shift_dr   <= bsr_sel && (state_d == SH_DR);
         update_dr  <= bsr_sel && (state_d == UPD_DR);
         tdo_en     <= (state_d == SH_DR) || (state_d == SH_IR);
      end
   end

   always_comb begin
      TDO = 1'b0;
      if (state_q == SH_IR)      TDO = ir_sr_q[0];
      else if (state_q == SH_DR) TDO = bsr_sel ? bsr_scan_out : bypass_q;
   end

   assign bsr_scan_in = TDI;
   assign mode        = (ir_q == EXTEST_OP);
   assign ir_out      = ir_q;
   assign tap_state   = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: per-cycle vector table through a scoreboard queue,
// a 3-cell BSR chain model, and a random bypass-latency sequence.
module tb_jtag_tap_ctrl;

   localparam logic [3:0] S_EX2_DR = 4'h0, S_EX1_DR = 4'h1, S_SH_DR  = 4'h2, S_PAU_DR = 4'h3;
   localparam logic [3:0] S_SEL_IR = 4'h4, S_UPD_DR = 4'h5, S_CAP_DR = 4'h6, S_SEL_DR = 4'h7;
   localparam logic [3:0] S_EX1_IR = 4'h9, S_SH_IR  = 4'hA;
   localparam logic [3:0] S_RTI    = 4'hC, S_UPD_IR = 4'hD, S_CAP_IR = 4'hE, S_TLR    = 4'hF;

   logic       TCK = 1'b0;
   logic       TRST = 1'b1;
   logic       TMS = 1'b0;
   logic       TDI = 1'b0;
   logic       bsr_scan_out;
   logic       TDO, tdo_en, bsr_scan_in, shift_dr, capture_dr, update_dr, mode;
   logic [3:0] ir_out;
   logic [3:0] tap_state;

   int errors = 0;
   int checks = 0;

   jtag_tap_ctrl dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_scan_out(bsr_scan_out),
      .TDO(TDO), .tdo_en(tdo_en), .bsr_scan_in(bsr_scan_in), .shift_dr(shift_dr),
      .capture_dr(capture_dr), .update_dr(update_dr), .mode(mode),
      .ir_out(ir_out), .tap_state(tap_state)
   );

   always #5 TCK = ~TCK;

   // Three BSR cells; capture loads 3'b110 so TDO shows 0,1,1.
   logic [2:0] chain = 3'b000;
   always @(posedge TCK) begin
      if (capture_dr)    chain <= 3'b110;
      else if (shift_dr) chain <= {bsr_scan_in, chain[2:1]};
   end
   assign bsr_scan_out = chain[0];

   typedef struct {
      logic       trst;
      logic       tms;
      logic       tdi;
      logic [3:0] st;
      logic [3:0] ir;
      logic [4:0] ctl;   // {tdo_en, capture_dr, shift_dr, update_dr, mode}
      logic       tdo;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   logic sbq[$];

   function automatic void add(logic trst, logic tms, logic tdi, logic [3:0] st,
                               logic [3:0] ir, logic [4:0] ctl, logic tdo);
      vec_t v;
      v.trst = trst; v.tms = tms; v.tdi = tdi;
      v.st = st; v.ir = ir; v.ctl = ctl; v.tdo = tdo;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(logic tms, logic tdi);
      @(negedge TCK);
      TRST = 1'b0; TMS = tms; TDI = tdi;
      @(posedge TCK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      // reset and five-ones
      add(1,0,0, S_TLR,    4'hF, 5'b00000, 0);
      add(0,1,0, S_TLR,    4'hF, 5'b00000, 0);
      add(0,0,0, S_RTI,    4'hF, 5'b00000, 0);
      add(0,1,0, S_SEL_DR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_SEL_IR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_TLR,    4'hF, 5'b00000, 0);
      add(0,1,0, S_TLR,    4'hF, 5'b00000, 0);
      add(0,1,0, S_TLR,    4'hF, 5'b00000, 0);
      add(0,0,0, S_RTI,    4'hF, 5'b00000, 0);
      // IR scan of EXTEST (0000)
      add(0,1,0, S_SEL_DR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_SEL_IR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_CAP_IR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_SH_IR,  4'hF, 5'b10000, 1);
      add(0,0,0, S_SH_IR,  4'hF, 5'b10000, 0);
      add(0,0,0, S_SH_IR,  4'hF, 5'b10000, 0);
      add(0,0,0, S_SH_IR,  4'hF, 5'b10000, 0);
      add(0,1,0, S_EX1_IR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_UPD_IR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_RTI,    4'h0, 5'b00001, 0);
      // TMS reset forces bypass and drops mode on entering TLR
      add(0,1,0, S_SEL_DR, 4'h0, 5'b00001, 0);
      add(0,1,0, S_SEL_IR, 4'h0, 5'b00001, 0);
      add(0,1,0, S_TLR,    4'hF, 5'b00000, 0);
      add(0,0,0, S_RTI,    4'hF, 5'b00000, 0);
      // bypass DR scan of 1,0,1,1
      add(0,1,0, S_SEL_DR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_CAP_DR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_SH_DR,  4'hF, 5'b10000, 0);
      add(0,0,1, S_SH_DR,  4'hF, 5'b10000, 1);
      add(0,0,0, S_SH_DR,  4'hF, 5'b10000, 0);
      add(0,0,1, S_SH_DR,  4'hF, 5'b10000, 1);
      add(0,1,1, S_EX1_DR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_UPD_DR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_RTI,    4'hF, 5'b00000, 0);
      // IR scan of SAMPLE (0001)
      add(0,1,0, S_SEL_DR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_SEL_IR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_CAP_IR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_SH_IR,  4'hF, 5'b10000, 1);
      add(0,0,1, S_SH_IR,  4'hF, 5'b10000, 0);
      add(0,0,0, S_SH_IR,  4'hF, 5'b10000, 0);
      add(0,0,0, S_SH_IR,  4'hF, 5'b10000, 0);
      add(0,1,0, S_EX1_IR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_UPD_IR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_RTI,    4'h1, 5'b00000, 0);
      // SAMPLE: 3-bit DR scan through the chain model
      add(0,1,0, S_SEL_DR, 4'h1, 5'b00000, 0);
      add(0,0,0, S_CAP_DR, 4'h1, 5'b01000, 0);
      add(0,0,0, S_SH_DR,  4'h1, 5'b10100, 0);
      add(0,0,1, S_SH_DR,  4'h1, 5'b10100, 1);
      add(0,0,0, S_SH_DR,  4'h1, 5'b10100, 1);
      add(0,1,1, S_EX1_DR, 4'h1, 5'b00000, 0);
      add(0,1,0, S_UPD_DR, 4'h1, 5'b00010, 0);
      add(0,0,0, S_RTI,    4'h1, 5'b00000, 0);
      // shift 2, pause 3, resume, shift 2: no recapture
      add(0,1,0, S_SEL_DR, 4'h1, 5'b00000, 0);
      add(0,0,0, S_CAP_DR, 4'h1, 5'b01000, 0);
      add(0,0,0, S_SH_DR,  4'h1, 5'b10100, 0);
      add(0,0,1, S_SH_DR,  4'h1, 5'b10100, 1);
      add(0,1,0, S_EX1_DR, 4'h1, 5'b00000, 0);
      add(0,0,0, S_PAU_DR, 4'h1, 5'b00000, 0);
      add(0,0,0, S_PAU_DR, 4'h1, 5'b00000, 0);
      add(0,0,0, S_PAU_DR, 4'h1, 5'b00000, 0);
      add(0,1,0, S_EX2_DR, 4'h1, 5'b00000, 0);
      add(0,0,0, S_SH_DR,  4'h1, 5'b10100, 1);
      add(0,0,1, S_SH_DR,  4'h1, 5'b10100, 1);
      add(0,1,0, S_EX1_DR, 4'h1, 5'b00000, 0);
      add(0,1,0, S_UPD_DR, 4'h1, 5'b00010, 0);
      add(0,0,0, S_RTI,    4'h1, 5'b00000, 0);
      // TRST mid-shift: no update pulse
      add(0,1,0, S_SEL_DR, 4'h1, 5'b00000, 0);
      add(0,0,0, S_CAP_DR, 4'h1, 5'b01000, 0);
      add(0,0,0, S_SH_DR,  4'h1, 5'b10100, 0);
      add(0,0,1, S_SH_DR,  4'h1, 5'b10100, 1);
      add(1,1,0, S_TLR,    4'hF, 5'b00000, 0);
      add(1,0,0, S_TLR,    4'hF, 5'b00000, 0);
      add(0,0,0, S_RTI,    4'hF, 5'b00000, 0);
      // four ones from SH_DR stay short of TLR, the fifth reaches it
      add(0,1,0, S_SEL_DR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_CAP_DR, 4'hF, 5'b00000, 0);
      add(0,0,0, S_SH_DR,  4'hF, 5'b10000, 0);
      add(0,1,0, S_EX1_DR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_UPD_DR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_SEL_DR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_SEL_IR, 4'hF, 5'b00000, 0);
      add(0,1,0, S_TLR,    4'hF, 5'b00000, 0);

      foreach (vecs[i]) begin
         @(negedge TCK);
         TRST = vecs[i].trst; TMS = vecs[i].tms; TDI = vecs[i].tdi;
         check($sformatf("row%0d scan_in", i), 32'(bsr_scan_in), 32'(vecs[i].tdi));
         sb.push_back(vecs[i]);
         @(posedge TCK);
         #1;
         e = sb.pop_front();
         check($sformatf("row%0d state", i), 32'(tap_state), 32'(e.st));
         check($sformatf("row%0d ir", i), 32'(ir_out), 32'(e.ir));
         check($sformatf("row%0d ctl", i),
               32'({tdo_en, capture_dr, shift_dr, update_dr, mode}), 32'(e.ctl));
         check($sformatf("row%0d tdo", i), 32'(TDO), 32'(e.tdo));
      end

      // random bypass stream: each TDI bit reappears on TDO one TCK later
      step(0, 0); step(1, 0); step(0, 0); step(0, 0);
      sbq.push_back(1'b0);
      for (int i = 0; i < 12; i++) begin
         logic b;
         @(negedge TCK);
         check($sformatf("byp%0d tdo", i), 32'(TDO), 32'(sbq.pop_front()));
         b = 1'($urandom_range(1));
         TDI = b;
         TMS = (i == 11);
         sbq.push_back(b);
         @(posedge TCK);
      end
      step(1, 0); step(0, 0);
      #1;
      check("byp end state", 32'(tap_state), 32'(S_RTI));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
